interrupt_controller: RTL and testbench

Collects peripheral interrupt lines, including the system timer's one-cycle `SysTimerInt` pulse on source 0. It latches rising edges into a pending register and arbitrates by fixed priority. It presents a single request plus source ID to the CPU through a request/acknowledge/end-of-interrupt handshake. Control and status registers sit on the I/O logic side of the peripheral bus, next to the timer in the I/O address map.

---
 rtl/interrupt_controller.sv | 131 +++++++++++++
 tb/tb_interrupt_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: edge-captured pending bits, CR/IER/IPR/EOI/STAT registers,
// single request to the CPU with request/ack/end-of-interrupt handshake (index 0 is highest priority).
module interrupt_controller #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [NUM_SRC-1:0] IrqIn,
  input  logic [3:0]         RegAddress,
  input  logic               BlockSelect,
  input  logic               WrEn,
  input  logic [31:0]        WrData,
  output logic [31:0]        RdData,
  output logic               IntReq,
  output logic [ID_W-1:0]    IntId,
  input  logic               IntAck
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  localparam logic [3:0] ADDR_CR   = 4'd0;
  localparam logic [3:0] ADDR_IER  = 4'd1;
  localparam logic [3:0] ADDR_IPR  = 4'd2;
  localparam logic [3:0] ADDR_EOI  = 4'd3;
  localparam logic [3:0] ADDR_STAT = 4'd4;

  state_t             state_q, state_d;
  logic               gie_q, gie_d;
  logic [NUM_SRC-1:0] ier_q, ier_d;
  logic [NUM_SRC-1:0] ipr_q, ipr_d;
  logic [NUM_SRC-1:0] irq_prev_q, irq_prev_d;
  logic [ID_W-1:0]    int_id_q, int_id_d;

  logic               wr_en;
  logic [NUM_SRC-1:0] irq_rise;
  logic [NUM_SRC-1:0] ipr_w1c;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] req_vec;
  logic [ID_W-1:0]    sel_id;
  logic               unused_wr_dat;

  assign unused_wr_dat = &{1'b0, WrData};

  always_comb begin
    wr_en      = BlockSelect & WrEn;
    gie_d      = gie_q;
    ier_d      = ier_q;
    irq_prev_d = IrqIn;
    int_id_d   = int_id_q;
    state_d    = state_q;
    ipr_w1c    = '0;
    ack_clr    = '0;
    irq_rise   = IrqIn & ~irq_prev_q;
    req_vec    = ipr_q & ier_q;

    if (wr_en && RegAddress == ADDR_CR)  gie_d   = WrData[0];
    if (wr_en && RegAddress == ADDR_IER) ier_d   = WrData[NUM_SRC-1:0];
    if (wr_en && RegAddress == ADDR_IPR) ipr_w1c = WrData[NUM_SRC-1:0];

    // Descending scan so the lowest set index is the one left in sel_id.
    sel_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_vec[i]) sel_id = ID_W'(i);
    end

    case (state_q)
      ST_IDLE: begin
        if (gie_q && (|req_vec)) begin
          int_id_d = sel_id;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (IntAck) begin
          ack_clr = NUM_SRC'(1) << int_id_q;
          state_d = ST_SERV;
        end
      end
      ST_SERV: begin
        if (wr_en && RegAddress == ADDR_EOI) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new edge outranks any clear landing on the same bit in the same cycle.
    ipr_d = (ipr_q & ~ipr_w1c & ~ack_clr) | irq_rise;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      gie_q      <= 1'b0;
      ier_q      <= '0;
      ipr_q      <= '0;
      irq_prev_q <= '0;
      int_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      gie_q      <= gie_d;
      ier_q      <= ier_d;
      ipr_q      <= ipr_d;
      irq_prev_q <= irq_prev_d;
      int_id_q   <= int_id_d;
    end
  end

  assign IntReq = (state_q == ST_REQ);
  assign IntId  = int_id_q;

  always_comb begin
    RdData = '0;
    if (BlockSelect) begin
      case (RegAddress)
        ADDR_CR:   RdData[0] = gie_q;
        ADDR_IER:  RdData[NUM_SRC-1:0] = ier_q;
        ADDR_IPR:  RdData[NUM_SRC-1:0] = ipr_q;
        ADDR_STAT: begin
          RdData[1:0]      = state_q;
          RdData[ID_W+3:4] = int_id_q;
        end
        default:   RdData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: per-feature tasks with inline expected values.
module tb_interrupt_controller;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 4;

  logic               Clock = 1'b0;
  logic               Reset;
  logic [NUM_SRC-1:0] IrqIn;
  logic [3:0]         RegAddress;
  logic               BlockSelect;
  logic               WrEn;
  logic [31:0]        WrData;
  logic [31:0]        RdData;
  logic               IntReq;
  logic [ID_W-1:0]    IntId;
  logic               IntAck;

  int checks = 0;
  int errors = 0;

  interrupt_controller #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .IrqIn       (IrqIn),
    .RegAddress  (RegAddress),
    .BlockSelect (BlockSelect),
    .WrEn        (WrEn),
    .WrData      (WrData),
    .RdData      (RdData),
    .IntReq      (IntReq),
    .IntId       (IntId),
    .IntAck      (IntAck)
  );

  always #5 Clock = ~Clock;

  // Advance one rising edge, then settle 1ns before touching inputs or sampling.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wr_reg(input logic [3:0] addr, input logic [31:0] data);
    BlockSelect = 1'b1; WrEn = 1'b1; RegAddress = addr; WrData = data;
    tick();
    BlockSelect = 1'b0; WrEn = 1'b0; WrData = '0;
  endtask

  task automatic rd_reg(input logic [3:0] addr, output logic [31:0] data);
    BlockSelect = 1'b1; WrEn = 1'b0; RegAddress = addr;
    #1;
    data = RdData;
    BlockSelect = 1'b0;
  endtask

  task automatic pulse_irq(input logic [NUM_SRC-1:0] mask);
    IrqIn = mask;
    tick();
    IrqIn = '0;
  endtask

  task automatic ack();
    IntAck = 1'b1;
    tick();
    IntAck = 1'b0;
  endtask

  task automatic test_reset_initial();
    logic [31:0] d;
    #1;
    checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL init_intreq: got %b want 0", IntReq); end
    checks++; if (IntId !== 4'd0) begin errors++; $display("FAIL init_intid: got %h want 0", IntId); end
    rd_reg(4'd4, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL init_stat: got %h want 0", d); end
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_single_source();
    logic [31:0] d;
    wr_reg(4'd0, 32'h1);
    wr_reg(4'd1, 32'h01);
    pulse_irq(8'h01);
    checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL single_req_early: got %b want 0", IntReq); end
    rd_reg(4'd2, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL single_ipr_set: got %h want 1", d); end
    tick();
    checks++; if (IntReq !== 1'b1 || IntId !== 4'd0) begin errors++; $display("FAIL single_req: got req=%b id=%h want req=1 id=0", IntReq, IntId); end
    ack();
    checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL single_ack_req: got %b want 0", IntReq); end
    rd_reg(4'd2, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL single_ack_ipr: got %h want 0", d); end
    rd_reg(4'd4, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL single_stat_serv: got %h want 2", d); end
    wr_reg(4'd3, 32'h0);
    rd_reg(4'd4, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL single_stat_idle: got %h want 0", d); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    wr_reg(4'd1, 32'hFF);
    pulse_irq(8'h24);
    tick();
    checks++; if (IntReq !== 1'b1 || IntId !== 4'd2) begin errors++; $display("FAIL prio_first: got req=%b id=%h want req=1 id=2", IntReq, IntId); end
    ack();
    wr_reg(4'd3, 32'h0);
    checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL prio_gap: got %b want 0", IntReq); end
    tick();
    checks++; if (IntReq !== 1'b1 || IntId !== 4'd5) begin errors++; $display("FAIL prio_second: got req=%b id=%h want req=1 id=5", IntReq, IntId); end
    ack();
    wr_reg(4'd3, 32'h0);
    rd_reg(4'd2, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL prio_ipr_empty: got %h want 0", d); end
  endtask

  task automatic test_masking();
    logic [31:0] d;
    wr_reg(4'd1, 32'h00);
    pulse_irq(8'h08);
    tick();
    tick();
    checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL mask_req: got %b want 0", IntReq); end
    rd_reg(4'd2, d);
    checks++; if (d !== 32'h08) begin errors++; $display("FAIL mask_ipr: got %h want 08", d); end
    wr_reg(4'd1, 32'h08);
    checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL mask_req_at_write: got %b want 0", IntReq); end
    tick();
    checks++; if (IntReq !== 1'b1 || IntId !== 4'd3) begin errors++; $display("FAIL mask_unmask_req: got req=%b id=%h want req=1 id=3", IntReq, IntId); end
    ack();
    wr_reg(4'd3, 32'h0);
  endtask

  task automatic test_collision();
    logic [31:0] d;
    // IER still 0x08, so source 1 only exercises the pending register.
    BlockSelect = 1'b1; WrEn = 1'b1; RegAddress = 4'd2; WrData = 32'h02; IrqIn = 8'h02;
    tick();
    BlockSelect = 1'b0; WrEn = 1'b0; WrData = '0;
    rd_reg(4'd2, d);
    checks++; if (d !== 32'h02) begin errors++; $display("FAIL coll_set_wins: got %h want 02", d); end
    wr_reg(4'd2, 32'h02);
    for (int i = 0; i < 10; i++) tick();
    rd_reg(4'd2, d);
    checks++; if (d !== 32'h00) begin errors++; $display("FAIL coll_held_high: got %h want 00", d); end
    IrqIn = '0;
    tick();
    checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL coll_no_req: got %b want 0", IntReq); end
  endtask

  task automatic test_protocol_errors();
    logic [31:0] d;
    wr_reg(4'd1, 32'h10);
    ack();
    rd_reg(4'd4, d);
    checks++; if (d !== 32'h30) begin errors++; $display("FAIL proto_ack_idle: got %h want 30", d); end
    pulse_irq(8'h10);
    tick();
    wr_reg(4'd3, 32'h0);
    rd_reg(4'd4, d);
    checks++; if (d !== 32'h41 || IntReq !== 1'b1) begin errors++; $display("FAIL proto_eoi_req: got stat=%h req=%b want stat=41 req=1", d, IntReq); end
    ack();
    pulse_irq(8'h10);
    rd_reg(4'd2, d);
    checks++; if (d !== 32'h10) begin errors++; $display("FAIL proto_serv_edge: got %h want 10", d); end
    rd_reg(4'd4, d);
    checks++; if (d !== 32'h42) begin errors++; $display("FAIL proto_serv_stat: got %h want 42", d); end
    wr_reg(4'd3, 32'h0);
    tick();
    checks++; if (IntReq !== 1'b1 || IntId !== 4'd4) begin errors++; $display("FAIL proto_rerequest: got req=%b id=%h want req=1 id=4", IntReq, IntId); end
    // Committed request survives GIE/IER/IPR changes, and ack still reaches SERV.
    wr_reg(4'd0, 32'h0);
    wr_reg(4'd1, 32'h0);
    wr_reg(4'd2, 32'h10);
    rd_reg(4'd2, d);
    checks++; if (d !== 32'h0 || IntReq !== 1'b1 || IntId !== 4'd4) begin errors++; $display("FAIL proto_committed: got ipr=%h req=%b id=%h want ipr=0 req=1 id=4", d, IntReq, IntId); end
    ack();
    rd_reg(4'd4, d);
    checks++; if (d !== 32'h42) begin errors++; $display("FAIL proto_ack_after_clear: got %h want 42", d); end
    wr_reg(4'd3, 32'h0);
  endtask

  task automatic test_reset_midreq();
    logic [31:0] d;
    wr_reg(4'd0, 32'h1);
    wr_reg(4'd1, 32'h40);
    pulse_irq(8'h40);
    tick();
    checks++; if (IntReq !== 1'b1 || IntId !== 4'd6) begin errors++; $display("FAIL rst_setup: got req=%b id=%h want req=1 id=6", IntReq, IntId); end
    #2;
    Reset = 1'b0;
    #1;
    checks++; if (IntReq !== 1'b0 || IntId !== 4'd0) begin errors++; $display("FAIL rst_outputs: got req=%b id=%h want req=0 id=0", IntReq, IntId); end
    rd_reg(4'd4, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_stat: got %h want 0", d); end
    rd_reg(4'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_cr: got %h want 0", d); end
    rd_reg(4'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ier: got %h want 0", d); end
    rd_reg(4'd2, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ipr: got %h want 0", d); end
    tick();
    Reset = 1'b1;
    tick();
    checks++; if (IntReq !== 1'b0) begin errors++; $display("FAIL rst_after_release: got %b want 0", IntReq); end
  endtask

  initial begin
    Reset = 1'b0; IrqIn = '0; RegAddress = '0; BlockSelect = 1'b0;
    WrEn = 1'b0; WrData = '0; IntAck = 1'b0;
    test_reset_initial();
    test_single_source();
    test_priority();
    test_masking();
    test_collision();
    test_protocol_errors();
    test_reset_midreq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
